bsg_relay_piso: RTL and testbench

Parallel-in, serial-out relay stage that sits directly downstream of `bsg_relay_fifo`. It accepts one `width_p`-bit word per valid/ready handshake and emits it as `els_p` chunks of `width_p/els_p` bits on a valid/ready output, least-significant chunk first. Both `ready_o` and `v_o` come straight from flops, so the block adds no combinational path between its upstream and downstream links. This keeps the relay property of the FIFO chain intact.

---
 rtl/bsg_relay_piso_pkg.sv | 21 ++
 rtl/bsg_relay_piso_ctr.sv | 42 ++++
 rtl/bsg_relay_piso.sv | 112 +++++++++++
 tb/tb_bsg_relay_piso.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_relay_piso_pkg.sv
// bsg_relay_piso_pkg
// Shared types and elaboration helpers for the bsg_relay_piso block.
//   bsg_relay_piso_state_e : FSM state (IDLE = empty, BUSY = holding a word)
//   chunk_width(w, e)      : bits per output chunk
//   cnt_width(e)           : chunk counter width, never less than 1 bit
package bsg_relay_piso_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bsg_relay_piso_state_e;

  function automatic int chunk_width(input int width, input int els);
    return width / els;
  endfunction

  function automatic int cnt_width(input int els);
    return (els <= 1) ? 1 : $clog2(els);
  endfunction

endpackage

// File: rtl/bsg_relay_piso_ctr.sv
// bsg_relay_piso_ctr
// Wrapping chunk counter: counts 0 .. els_p-1 and wraps to 0 on the step
// taken while at els_p-1, so it never holds els_p.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   clear_i          : force the count to 0 (word load); wins over up_i
//   up_i             : advance by one (chunk handshake)
//   count_o          : current count
//   last_o           : count is at els_p-1 (final chunk of the word)
module bsg_relay_piso_ctr
  import bsg_relay_piso_pkg::*;
#(
  parameter int els_p = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           clear_i,
  input  logic                           up_i,
  output logic [cnt_width(els_p)-1:0]    count_o,
  output logic                           last_o
);

  localparam int CNT_W = cnt_width(els_p);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(els_p - 1);

  logic [CNT_W-1:0] cnt_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r <= '0;
    end else if (clear_i) begin
      cnt_r <= '0;
    end else if (up_i) begin
      cnt_r <= (cnt_r == LAST_C) ? '0 : cnt_r + CNT_W'(1);
    end
  end

  assign count_o = cnt_r;
  // With els_p == 1 the count is pinned at 0 and every chunk is the last.
  assign last_o  = (cnt_r == LAST_C);

endmodule

// File: rtl/bsg_relay_piso.sv
// bsg_relay_piso
// Parallel-in, serial-out relay stage. Takes one width_p-bit word per
// upstream handshake and emits it as els_p chunks, least-significant first.
// ready_o and v_o decode the state flop only, so no combinational path
// exists between the upstream and downstream links.
// Optional feature macro: BSG_RELAY_PISO_LAST_EN adds last_o.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   v_i, data_i      : upstream word valid / word
//   ready_o          : block is empty and can take a word
//   v_o, data_o      : output chunk valid / chunk
//   ready_i          : downstream accepts the chunk
//   state_o, cnt_o   : debug view of the FSM state and chunk counter
//   last_o           : current chunk is the word's final chunk (macro only)
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high. Upstream holds v_i/data_i until it sees ready_o; downstream may
// drop ready_i at any time and data_o stays stable until accepted.
module bsg_relay_piso
  import bsg_relay_piso_pkg::*;
#(
  parameter int width_p = 16,
  parameter int els_p   = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         v_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         ready_o,
  output logic                         v_o,
  output logic [width_p/els_p-1:0]     data_o,
  input  logic                         ready_i,
  output bsg_relay_piso_state_e        state_o,
  output logic [cnt_width(els_p)-1:0]  cnt_o
`ifdef BSG_RELAY_PISO_LAST_EN
  ,
  output logic                         last_o
`endif
);

  localparam int CHUNK_W = chunk_width(width_p, els_p);
  localparam int CNT_W   = cnt_width(els_p);

  if (els_p < 1) begin : g_bad_els
    $error("bsg_relay_piso: els_p must be >= 1");
  end else if (width_p % els_p != 0) begin : g_bad_width
    $error("bsg_relay_piso: width_p must be divisible by els_p");
  end

  bsg_relay_piso_state_e state_r, w_state_n;
  logic [width_p-1:0]    shift_r, w_shift_n;
  logic                  w_clear, w_up, w_cnt_last;
  logic [CNT_W-1:0]      w_cnt;

  bsg_relay_piso_ctr #(
    .els_p (els_p)
  ) u_ctr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (w_clear),
    .up_i      (w_up),
    .count_o   (w_cnt),
    .last_o    (w_cnt_last)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      shift_r <= '0;
    end else begin
      state_r <= w_state_n;
      shift_r <= w_shift_n;
    end
  end

  always_comb begin
    w_state_n = state_r;
    w_shift_n = shift_r;
    w_clear   = 1'b0;
    w_up      = 1'b0;
    case (state_r)
      IDLE: begin
        // ready_i is ignored here
        if (v_i) begin
          w_shift_n = data_i;
          w_clear   = 1'b1;
          w_state_n = BUSY;
        end
      end
      BUSY: begin
        // v_i is ignored here; the block does not accept during its last
        // chunk, which keeps ready_o a pure state decode.
        if (ready_i) begin
          w_shift_n = shift_r >> CHUNK_W;
          w_up      = 1'b1;
          if (w_cnt_last) w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign ready_o = (state_r == IDLE);
  assign v_o     = (state_r == BUSY);
  assign data_o  = shift_r[CHUNK_W-1:0];
  assign state_o = state_r;
  assign cnt_o   = w_cnt;

`ifdef BSG_RELAY_PISO_LAST_EN
  assign last_o = v_o & w_cnt_last;
`endif

endmodule

// File: tb/tb_bsg_relay_piso.sv
// tb_bsg_relay_piso
// Directed bench for bsg_relay_piso: a 16/4 instance for the main scenarios
// and a 16/1 instance for the degenerate single-chunk case.
// Honours BSG_RELAY_PISO_LAST_EN when it is defined for the build.
module tb_bsg_relay_piso;
  import bsg_relay_piso_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // ---------------- dut0: width 16, els 4 ----------------
  logic                  v_i, ready_o, v_o, ready_i;
  logic [15:0]           data_i;
  logic [3:0]            data_o;
  bsg_relay_piso_state_e state_o;
  logic [1:0]            cnt_o;
`ifdef BSG_RELAY_PISO_LAST_EN
  logic                  last_o;
`endif

  bsg_relay_piso #(.width_p(16), .els_p(4)) u_dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .v_i       (v_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .v_o       (v_o),
    .data_o    (data_o),
    .ready_i   (ready_i),
    .state_o   (state_o),
    .cnt_o     (cnt_o)
`ifdef BSG_RELAY_PISO_LAST_EN
    ,
    .last_o    (last_o)
`endif
  );

  // ---------------- dut1: width 16, els 1 ----------------
  logic                  v1_i, ready1_o, v1_o, ready1_i;
  logic [15:0]           data1_i, data1_o;
  bsg_relay_piso_state_e state1_o;
  logic [0:0]            cnt1_o;
`ifdef BSG_RELAY_PISO_LAST_EN
  logic                  last1_o;
`endif

  bsg_relay_piso #(.width_p(16), .els_p(1)) u_dut1 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .v_i       (v1_i),
    .data_i    (data1_i),
    .ready_o   (ready1_o),
    .v_o       (v1_o),
    .data_o    (data1_o),
    .ready_i   (ready1_i),
    .state_o   (state1_o),
    .cnt_o     (cnt1_o)
`ifdef BSG_RELAY_PISO_LAST_EN
    ,
    .last_o    (last1_o)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // advance to just after the next active edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    tick(); tick();
    n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    n_vec++; if (v_o !== 1'b0) begin n_err++; $display("FAIL reset_v got=%b exp=0", v_o); end
    n_vec++; if (data_o !== 4'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", data_o); end
    n_vec++; if (state_o !== IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", state_o, IDLE); end
    n_vec++; if (cnt_o !== 2'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", cnt_o); end
    n_vec++; if (ready1_o !== 1'b1 || v1_o !== 1'b0 || data1_o !== 16'h0) begin
      n_err++; $display("FAIL reset_els1 got rdy=%b v=%b d=%h exp rdy=1 v=0 d=0000", ready1_o, v1_o, data1_o);
    end
`ifdef BSG_RELAY_PISO_LAST_EN
    n_vec++; if (last_o !== 1'b0) begin n_err++; $display("FAIL reset_last got=%b exp=0", last_o); end
`endif
    #4 reset_n = 1'b1;   // release mid-cycle, away from the edge
  endtask

  task automatic test_basic;
    logic [3:0] exp_c [4];
    exp_c = '{4'hD, 4'hC, 4'hB, 4'hA};
    ready_i = 1'b1; v_i = 1'b1; data_i = 16'hABCD;
    tick();
    v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (v_o !== 1'b1 || data_o !== exp_c[k]) begin
        n_err++; $display("FAIL basic_chunk%0d got v=%b d=%h exp v=1 d=%h", k, v_o, data_o, exp_c[k]);
      end
      n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL basic_ready%0d got=%b exp=0", k, ready_o); end
`ifdef BSG_RELAY_PISO_LAST_EN
      n_vec++; if (last_o !== (k == 3)) begin n_err++; $display("FAIL basic_last%0d got=%b exp=%b", k, last_o, (k == 3)); end
`endif
      tick();
    end
    n_vec++; if (ready_o !== 1'b1 || v_o !== 1'b0) begin
      n_err++; $display("FAIL basic_done got rdy=%b v=%b exp rdy=1 v=0", ready_o, v_o);
    end
  endtask

  task automatic test_backpressure;
    logic       pat [7];
    logic [3:0] exp_c [4];
    int idx, hs_obs;
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_c = '{4'h4, 4'h3, 4'h2, 4'h1};
    ready_i = 1'b0; v_i = 1'b1; data_i = 16'h1234;
    tick();
    v_i = 1'b0;
    idx = 0; hs_obs = 0;
    for (int k = 0; k < 7; k++) begin
      ready_i = pat[k];
      n_vec++; if (v_o !== 1'b1 || data_o !== exp_c[idx]) begin
        n_err++; $display("FAIL bp_cycle%0d got v=%b d=%h exp v=1 d=%h", k, v_o, data_o, exp_c[idx]);
      end
      if (v_o && ready_i) hs_obs++;
      if (pat[k]) idx++;
      tick();
    end
    ready_i = 1'b1;
    n_vec++; if (hs_obs !== 4) begin n_err++; $display("FAIL bp_handshakes got=%0d exp=4", hs_obs); end
    n_vec++; if (v_o !== 1'b0 || ready_o !== 1'b1) begin
      n_err++; $display("FAIL bp_done got v=%b rdy=%b exp v=0 rdy=1", v_o, ready_o);
    end
  endtask

  task automatic test_streaming;
    logic [15:0] words [3];
    logic [3:0]  exp_s [12];
    logic        acc, hs;
    logic [3:0]  d;
    int wi, got, cyc;
    words = '{16'h0001, 16'hFFFF, 16'h8000};
    exp_s = '{4'h1, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h8};
    ready_i = 1'b1; wi = 0; got = 0; cyc = 0;
    v_i = 1'b1; data_i = words[0];
    while (got < 12 && cyc < 40) begin
      acc = v_i & ready_o; hs = v_o & ready_i; d = data_o;
      tick(); cyc++;
      if (hs) begin
        n_vec++; if (d !== exp_s[got]) begin n_err++; $display("FAIL stream_chunk%0d got=%h exp=%h", got, d, exp_s[got]); end
        got++;
      end
      if (acc) begin
        wi++;
        if (wi < 3) data_i = words[wi];
        else v_i = 1'b0;
      end
    end
    v_i = 1'b0;
    n_vec++; if (got !== 12) begin n_err++; $display("FAIL stream_count got=%0d exp=12", got); end
    n_vec++; if (cyc !== 15) begin n_err++; $display("FAIL stream_cycles got=%0d exp=15", cyc); end
    tick();
  endtask

  task automatic test_reset_mid;
    logic [3:0] exp_c [4];
    exp_c = '{4'hA, 4'h5, 4'hA, 4'h5};
    ready_i = 1'b1; v_i = 1'b1; data_i = 16'hBEEF;
    tick();                 // accept, F shown
    v_i = 1'b0;
    tick(); tick();         // F and E taken, second E shown
    n_vec++; if (v_o !== 1'b1 || data_o !== 4'hE) begin
      n_err++; $display("FAIL rmid_pre got v=%b d=%h exp v=1 d=e", v_o, data_o);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (v_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 4'h0) begin
      n_err++; $display("FAIL rmid_async got v=%b rdy=%b d=%h exp v=0 rdy=1 d=0", v_o, ready_o, data_o);
    end
    #1 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (v_o !== 1'b0) begin n_err++; $display("FAIL rmid_stale%0d got v=%b d=%h exp v=0", k, v_o, data_o); end
    end
    v_i = 1'b1; data_i = 16'h5A5A;
    tick();
    v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (v_o !== 1'b1 || data_o !== exp_c[k]) begin
        n_err++; $display("FAIL rmid_next%0d got v=%b d=%h exp v=1 d=%h", k, v_o, data_o, exp_c[k]);
      end
      tick();
    end
  endtask

  task automatic test_els1;
    ready1_i = 1'b1; v1_i = 1'b1; data1_i = 16'hCAFE;
    tick();
    n_vec++; if (v1_o !== 1'b1 || data1_o !== 16'hCAFE || ready1_o !== 1'b0) begin
      n_err++; $display("FAIL els1_word0 got v=%b d=%h rdy=%b exp v=1 d=cafe rdy=0", v1_o, data1_o, ready1_o);
    end
`ifdef BSG_RELAY_PISO_LAST_EN
    n_vec++; if (last1_o !== 1'b1) begin n_err++; $display("FAIL els1_last got=%b exp=1", last1_o); end
`endif
    data1_i = 16'h1357;
    tick();
    n_vec++; if (v1_o !== 1'b0 || ready1_o !== 1'b1) begin
      n_err++; $display("FAIL els1_gap got v=%b rdy=%b exp v=0 rdy=1", v1_o, ready1_o);
    end
    tick();
    v1_i = 1'b0;
    n_vec++; if (v1_o !== 1'b1 || data1_o !== 16'h1357) begin
      n_err++; $display("FAIL els1_word1 got v=%b d=%h exp v=1 d=1357", v1_o, data1_o);
    end
    tick();
    n_vec++; if (v1_o !== 1'b0 || ready1_o !== 1'b1) begin
      n_err++; $display("FAIL els1_done got v=%b rdy=%b exp v=0 rdy=1", v1_o, ready1_o);
    end
    ready1_i = 1'b0;
  endtask

  task automatic test_random;
    logic [3:0]  exp_q [$];
    logic [15:0] w;
    logic [3:0]  d, e;
    logic        acc, hs;
    int sent, rcv, cyc;
    sent = 0; rcv = 0; cyc = 0; v_i = 1'b0;
    while (rcv < 32 && cyc < 2000) begin
      if (!v_i && sent < 8 && $urandom_range(0, 3) != 0) begin
        v_i = 1'b1; data_i = 16'($urandom_range(0, 65535));
      end
      ready_i = 1'($urandom_range(0, 1));
      acc = v_i & ready_o; hs = v_o & ready_i; d = data_o; w = data_i;
      tick(); cyc++;
      if (acc) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(w[4*k +: 4]);
        sent++; v_i = 1'b0;
      end
      if (hs) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_extra got=%h exp=none", d);
        end else begin
          e = exp_q.pop_front();
          if (d !== e) begin n_err++; $display("FAIL rand_chunk%0d got=%h exp=%h", rcv, d, e); end
        end
        rcv++;
      end
    end
    v_i = 1'b0; ready_i = 1'b0;
    n_vec++; if (rcv !== 32) begin n_err++; $display("FAIL rand_count got=%0d exp=32", rcv); end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    v_i = 1'b0; data_i = '0; ready_i = 1'b0;
    v1_i = 1'b0; data1_i = '0; ready1_i = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    test_els1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
